// File: rtl/bitsparse_pkg.sv
// Shared widths and types for the bit-sparsity front end.
// Sets the operand width and the width of an emitted bit index.
package bitsparse_pkg;
  localparam int WIDTH   = 8;
  localparam int PLACE_W = $clog2(WIDTH);

  typedef logic [WIDTH-1:0]   value_t;
  typedef logic [PLACE_W-1:0] place_t;
endpackage

// File: rtl/values_to_bit_converter_lsb_enc.sv
// Lowest-set-bit priority encoder, lowest index wins.
// in: value; out: idx, any (value != 0), cleared (value, idx bit cleared)
module lowest_set_bit_encoder
  import bitsparse_pkg::*;
(
  input  logic [WIDTH-1:0]   value,
  output logic [PLACE_W-1:0] idx,
  output logic               any,
  output logic [WIDTH-1:0]   cleared
);

  // The scan runs high to low, so the last hit is the lowest index.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (value[i]) begin
        idx = PLACE_W'(i);
        any = 1'b1;
      end
    end
  end

  // x & (x-1) drops the lowest set bit. When x is 0 the result is also 0.
  assign cleared = value & (value - WIDTH'(1));

endmodule

// File: rtl/values_to_bit_converter.sv
// Emits the set-bit positions of each accepted operand, LSB first, one per clock.
// in: CLK, RST, InputValue/InputValid; out: InputReady, BitPlace/BitValid/BitLast, ZeroValue
module values_to_bit_converter
  import bitsparse_pkg::*;
(
  input  logic               CLK,
  input  logic               RST,
  input  logic [WIDTH-1:0]   InputValue,
  input  logic               InputValid,
  output logic               InputReady,
  output logic [PLACE_W-1:0] BitPlace,
  output logic               BitValid,
  output logic               BitLast,
  output logic               ZeroValue
);

  value_t remaining_q, remaining_d;
  place_t place_q, place_d;
  logic   valid_q, valid_d;
  logic   last_q, last_d;
  logic   zero_q, zero_d;

  place_t rem_idx, in_idx;
  logic   rem_any, in_any;
  value_t rem_clr, in_clr;
  logic   accept;

  lowest_set_bit_encoder u_rem_enc (
    .value   (remaining_q),
    .idx     (rem_idx),
    .any     (rem_any),
    .cleared (rem_clr)
  );

  lowest_set_bit_encoder u_in_enc (
    .value   (InputValue),
    .idx     (in_idx),
    .any     (in_any),
    .cleared (in_clr)
  );

  assign InputReady = ~rem_any;
  assign accept     = InputValid & InputReady;

  always_comb begin
    remaining_d = remaining_q;
    place_d     = place_q;
    valid_d     = 1'b0;
    last_d      = 1'b0;
    zero_d      = 1'b0;
    if (rem_any) begin
      place_d     = rem_idx;
      valid_d     = 1'b1;
      last_d      = (rem_clr == '0);
      remaining_d = rem_clr;
    end else if (accept) begin
      if (in_any) begin
        place_d     = in_idx;
        valid_d     = 1'b1;
        last_d      = (in_clr == '0);
        remaining_d = in_clr;
      end else begin
        zero_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      remaining_q <= '0;
      place_q     <= '0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      remaining_q <= remaining_d;
      place_q     <= place_d;
      valid_q     <= valid_d;
      last_q      <= last_d;
      zero_q      <= zero_d;
    end
  end

  assign BitPlace  = place_q;
  assign BitValid  = valid_q;
  assign BitLast   = last_q;
  assign ZeroValue = zero_q;

endmodule

// File: tb/tb_values_to_bit_converter.sv
// Bench for values_to_bit_converter: queue model plus directed checks.
// Model compares every cycle; literal checks pin the directed scenarios.
module tb_values_to_bit_converter;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] InputValue = 8'h00;
  logic       InputValid = 1'b0;
  logic       InputReady;
  logic [2:0] BitPlace;
  logic       BitValid;
  logic       BitLast;
  logic       ZeroValue;

  int n_cmp = 0;
  int n_bad = 0;

  values_to_bit_converter dut (
    .CLK        (CLK),
    .RST        (RST),
    .InputValue (InputValue),
    .InputValid (InputValid),
    .InputReady (InputReady),
    .BitPlace   (BitPlace),
    .BitValid   (BitValid),
    .BitLast    (BitLast),
    .ZeroValue  (ZeroValue)
  );

  always #5 CLK = ~CLK;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: pending positions of the current operand, in emission order.
  int   pend[$];
  logic e_valid, e_last, e_zero;
  int   e_place = 0;

  always @(posedge CLK) begin
    e_valid = 1'b0;
    e_last  = 1'b0;
    e_zero  = 1'b0;
    if (RST) begin
      pend.delete();
      e_place = 0;
    end else begin
      if (pend.size() == 0 && InputValid) begin
        if (InputValue == 8'h00) e_zero = 1'b1;
        for (int i = 0; i < 8; i++)
          if (InputValue[i]) pend.push_back(i);
      end
      if (pend.size() != 0) begin
        e_place = pend.pop_front();
        e_valid = 1'b1;
        e_last  = (pend.size() == 0);
      end
    end
    #1;
    chk("m_valid", 32'(BitValid), 32'(e_valid));
    chk("m_last",  32'(BitLast),  32'(e_last));
    chk("m_zero",  32'(ZeroValue), 32'(e_zero));
    chk("m_place", 32'(BitPlace), 32'(e_place));
    chk("m_ready", 32'(InputReady), 32'(pend.size() == 0));
  end

  task automatic wait_ready();
    int n;
    n = 0;
    while (InputReady !== 1'b1 && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (InputReady !== 1'b1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL ready_timeout: InputReady=%b expected 1", InputReady);
    end
  endtask

  // Presents one operand for a single accept edge; returns at the next negedge.
  task automatic send(logic [7:0] v);
    wait_ready();
    InputValue = v;
    InputValid = 1'b1;
    @(negedge CLK);
    InputValid = 1'b0;
  endtask

  logic [2:0] f7_seq [7] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd6, 3'd7};

  initial begin
    RST        = 1'b1;
    InputValid = 1'b1;
    InputValue = 8'h55;
    repeat (2) @(negedge CLK);
    chk("rst_valid", 32'(BitValid), 32'd0);
    chk("rst_place", 32'(BitPlace), 32'd0);
    chk("rst_zero",  32'(ZeroValue), 32'd0);
    RST        = 1'b0;
    InputValid = 1'b0;
    @(negedge CLK);
    chk("rel_ready", 32'(InputReady), 32'd1);
    chk("rel_valid", 32'(BitValid), 32'd0);

    // 0x03
    send(8'h03);
    chk("x03_p0", 32'(BitPlace), 32'd0);
    chk("x03_l0", 32'(BitLast), 32'd0);
    chk("x03_r0", 32'(InputReady), 32'd0);
    @(negedge CLK);
    chk("x03_p1", 32'(BitPlace), 32'd1);
    chk("x03_l1", 32'(BitLast), 32'd1);
    chk("x03_r1", 32'(InputReady), 32'd1);
    @(negedge CLK);
    chk("x03_idle_v", 32'(BitValid), 32'd0);
    chk("x03_hold_p", 32'(BitPlace), 32'd1);

    // 0xF7 with input disturbed mid-sequence
    send(8'hF7);
    for (int k = 0; k < 7; k++) begin
      chk("xf7_v", 32'(BitValid), 32'd1);
      chk("xf7_p", 32'(BitPlace), 32'(f7_seq[k]));
      chk("xf7_l", 32'(BitLast), 32'(k == 6));
      if (k == 1) begin
        InputValue = 8'h01;
        InputValid = 1'b1;
      end
      if (k == 3) InputValid = 1'b0;
      @(negedge CLK);
    end
    chk("xf7_end_v", 32'(BitValid), 32'd0);

    // zero operand
    send(8'h00);
    chk("zero_pulse", 32'(ZeroValue), 32'd1);
    chk("zero_v", 32'(BitValid), 32'd0);
    chk("zero_r", 32'(InputReady), 32'd1);
    @(negedge CLK);
    chk("zero_end", 32'(ZeroValue), 32'd0);

    // back-to-back 0x80 then 0x01
    wait_ready();
    InputValue = 8'h80;
    InputValid = 1'b1;
    @(negedge CLK);
    chk("b2b_p7", 32'(BitPlace), 32'd7);
    chk("b2b_l7", 32'(BitLast), 32'd1);
    InputValue = 8'h01;
    @(negedge CLK);
    InputValid = 1'b0;
    chk("b2b_v0", 32'(BitValid), 32'd1);
    chk("b2b_p0", 32'(BitPlace), 32'd0);
    chk("b2b_l0", 32'(BitLast), 32'd1);
    @(negedge CLK);

    // reset mid-operand
    send(8'hFF);
    chk("ff_p0", 32'(BitPlace), 32'd0);
    @(negedge CLK);
    chk("ff_p1", 32'(BitPlace), 32'd1);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk("mrst_v", 32'(BitValid), 32'd0);
    chk("mrst_p", 32'(BitPlace), 32'd0);
    chk("mrst_l", 32'(BitLast), 32'd0);
    chk("mrst_r", 32'(InputReady), 32'd1);
    send(8'h10);
    chk("x10_v", 32'(BitValid), 32'd1);
    chk("x10_p", 32'(BitPlace), 32'd4);
    chk("x10_l", 32'(BitLast), 32'd1);
    repeat (3) @(negedge CLK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
